// File: rtl/dequant_pipe.sv
// Three-stage multi-lane dequantizer: each lane is scaled by X_s*w_s, optionally
// rounded half-up, shifted right by FRAC_W and saturated to DATA_W bits.
module dequant_pipe #(
  parameter int LANES   = 4,
  parameter int DATA_W  = 32,
  parameter int SCALE_W = 16,
  parameter int FRAC_W  = 16,
  parameter int ROUND   = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [31:0]               i_X_s,
  input  logic [31:0]               i_w_s,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [LANES*DATA_W-1:0]   i_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [LANES*DATA_W-1:0]   o_data,
  output logic [LANES-1:0]          o_sat,
  output logic                      o_busy
);

  localparam int SW2 = 2 * SCALE_W;
  localparam int PW  = DATA_W + SW2;
  localparam int RND_SH = (FRAC_W > 0) ? FRAC_W - 1 : 0;
  localparam logic [PW:0] RND =
    (ROUND != 0 && FRAC_W > 0) ? ({{PW{1'b0}}, 1'b1} << RND_SH) : '0;

  if (ROUND != 0 && FRAC_W == 0) begin : g_bad_cfg
    $error("dequant_pipe: ROUND=1 requires FRAC_W > 0");
  end

  // Handshake: a beat moves on a rising edge when valid && ready are both high.
  // The whole pipe advances together; it only freezes while S3 holds a beat
  // that downstream is refusing, so bubbles are held as well.
  logic advance;
  logic take;

  logic                      s1_valid;
  logic [LANES*DATA_W-1:0]   s1_data;
  logic [SW2-1:0]            s1_scale;
  logic                      s2_valid;
  logic [LANES-1:0][PW-1:0]  s2_prod;
  logic                      s3_valid;

  logic [SW2-1:0]            scale_in;
  logic [LANES-1:0][PW-1:0]  prod_next;
  logic [LANES*DATA_W-1:0]   data_next;
  logic [LANES-1:0]          sat_next;
  logic [PW:0]               sum;
  logic [PW:0]               q;

  logic unused_scale_bits;
  assign unused_scale_bits = ^{i_X_s[31:SCALE_W], i_w_s[31:SCALE_W]};

  assign advance = !s3_valid || i_ready;
  assign take    = i_valid && advance;
  assign o_ready = advance;
  assign o_valid = s3_valid;
  assign o_busy  = s1_valid | s2_valid | s3_valid;

  assign scale_in = {{SCALE_W{1'b0}}, i_X_s[SCALE_W-1:0]}
                  * {{SCALE_W{1'b0}}, i_w_s[SCALE_W-1:0]};

  always_comb begin
    prod_next = '0;
    for (int k = 0; k < LANES; k++) begin
      prod_next[k] = {{SW2{1'b0}}, s1_data[k*DATA_W +: DATA_W]}
                   * {{DATA_W{1'b0}}, s1_scale};
    end
  end

  // The extra top bit on sum keeps the rounding add from wrapping.
  always_comb begin
    data_next = '0;
    sat_next  = '0;
    sum       = '0;
    q         = '0;
    for (int k = 0; k < LANES; k++) begin
      sum = {1'b0, s2_prod[k]} + RND;
      q   = sum >> FRAC_W;
      if (|q[PW:DATA_W]) begin
        data_next[k*DATA_W +: DATA_W] = '1;
        sat_next[k]                   = 1'b1;
      end else begin
        data_next[k*DATA_W +: DATA_W] = q[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_data  <= '0;
      s1_scale <= '0;
      s2_prod  <= '0;
      o_data   <= '0;
      o_sat    <= '0;
    end else if (advance) begin
      s1_valid <= take;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      if (take) begin
        s1_data  <= i_data;
        s1_scale <= scale_in;
      end
      if (s1_valid) s2_prod <= prod_next;
      if (s2_valid) begin
        o_data <= data_next;
        o_sat  <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_dequant_pipe.sv
// Directed bench for dequant_pipe: a rounding and a truncating instance share
// stimulus; a queue-based model predicts every beat of both.
module tb_dequant_pipe;
  localparam int LANES  = 4;
  localparam int DATA_W = 32;
  localparam int DW     = LANES * DATA_W;
  localparam int EW     = 2 * (DW + LANES);

  logic            i_clk = 1'b0;
  logic            i_reset = 1'b1;
  logic [31:0]     i_X_s = '0;
  logic [31:0]     i_w_s = '0;
  logic            i_valid = 1'b0;
  logic [DW-1:0]   i_data = '0;
  logic            i_ready = 1'b1;
  logic            o_ready, o_valid, o_busy;
  logic [DW-1:0]   o_data;
  logic [LANES-1:0] o_sat;
  logic            o_ready_t, o_valid_t, o_busy_t;
  logic [DW-1:0]   o_data_t;
  logic [LANES-1:0] o_sat_t;

  dequant_pipe #(.ROUND(1)) u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_X_s(i_X_s), .i_w_s(i_w_s),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_sat(o_sat), .o_busy(o_busy));

  dequant_pipe #(.ROUND(0)) u_trunc (
    .i_clk(i_clk), .i_reset(i_reset), .i_X_s(i_X_s), .i_w_s(i_w_s),
    .i_valid(i_valid), .o_ready(o_ready_t), .i_data(i_data), .o_valid(o_valid_t),
    .i_ready(i_ready), .o_data(o_data_t), .o_sat(o_sat_t), .o_busy(o_busy_t));

  // clock / reset
  always #5 i_clk = ~i_clk;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endfunction

  // model: plain wide arithmetic straight from the dequant formula
  function automatic void model(input logic [DW-1:0] d, input logic [31:0] xs,
                                input logic [31:0] ws, input bit rnd,
                                output logic [DW-1:0] od, output logic [LANES-1:0] os);
    logic [95:0] v;
    od = '0;
    os = '0;
    for (int k = 0; k < LANES; k++) begin
      v = 96'(d[k*DATA_W +: DATA_W]) * 96'(xs[15:0]) * 96'(ws[15:0]);
      if (rnd) v = v + 96'd32768;
      v = v >> 16;
      if (v > 96'hFFFF_FFFF) begin
        od[k*DATA_W +: DATA_W] = 32'hFFFF_FFFF;
        os[k] = 1'b1;
      end else begin
        od[k*DATA_W +: DATA_W] = v[31:0];
      end
    end
  endfunction

  // scoreboard
  logic [EW-1:0]    exp_q[$];
  int               acc_q[$];
  int               inflight = 0;
  bit               chk_lat = 1'b1;
  bit               hold_valid = 1'b0;
  logic [DW-1:0]    hold_data;
  logic [LANES-1:0] hold_sat;
  int               ready_low = 0;
  int               n_out = 0;
  logic [DW-1:0]    last_data = '0, prev_data = '0, last_trunc = '0;
  logic [LANES-1:0] last_sat = '0;

  always @(negedge i_clk) begin
    logic [EW-1:0]    e;
    logic [DW-1:0]    od_r, od_t;
    logic [LANES-1:0] os_r, os_t;
    int a;
    if (i_reset) begin
      exp_q.delete();
      acc_q.delete();
      inflight   = 0;
      hold_valid = 1'b0;
    end else begin
      check("ready_rule", 128'(o_ready), 128'(!o_valid || i_ready));
      check("busy", 128'(o_busy), 128'(inflight != 0));
      if (hold_valid) begin
        check("hold_data", o_data, hold_data);
        check("hold_sat", 128'(o_sat), 128'(hold_sat));
      end
      hold_valid = o_valid && !i_ready;
      hold_data  = o_data;
      hold_sat   = o_sat;
      if (!o_ready) ready_low++;
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 128'(o_valid), 128'(0));
        else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("data", o_data, e[EW-1 -: DW]);
          check("sat", 128'(o_sat), 128'(e[DW+2*LANES-1 -: LANES]));
          check("trunc_valid", 128'(o_valid_t), 128'(1));
          check("trunc_data", o_data_t, e[LANES +: DW]);
          check("trunc_sat", 128'(o_sat_t), 128'(e[LANES-1:0]));
          if (chk_lat) check("latency", 128'(cyc - a), 128'(3));
          prev_data  = last_data;
          last_data  = o_data;
          last_trunc = o_data_t;
          last_sat   = o_sat;
          n_out++;
        end
        inflight--;
      end
      if (i_valid && o_ready) begin
        model(i_data, i_X_s, i_w_s, 1'b1, od_r, os_r);
        model(i_data, i_X_s, i_w_s, 1'b0, od_t, os_t);
        exp_q.push_back({od_r, os_r, od_t, os_t});
        acc_q.push_back(cyc);
        inflight++;
      end
    end
  end

  // driver tasks
  task automatic send_beat(input logic [DW-1:0] d, input logic [31:0] xs,
                           input logic [31:0] ws);
    int  n = 0;
    bit  ok = 1'b0;
    i_valid = 1'b1;
    i_data  = d;
    i_X_s   = xs;
    i_w_s   = ws;
    do begin
      @(negedge i_clk);
      ok = o_ready;
      n++;
      @(posedge i_clk);
      #1;
    end while (!ok && n < 100);
    if (!ok) fail_now("send_timeout");
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 100) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if (n >= 100) fail_now("drain_timeout");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_o_valid", 128'(o_valid), 128'(0));
    check("rst_o_data", o_data, 128'(0));
    check("rst_o_sat", 128'(o_sat), 128'(0));
    check("rst_o_busy", 128'(o_busy), 128'(0));
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    check("rst_o_ready", 128'(o_ready), 128'(1));

    // identity scale
    send_beat({32'h0000_FFFF, 32'd7, 32'd0, 32'd1000}, 32'h100, 32'h100);
    wait_drain();
    check("identity_lit", last_data, {32'h0000_FFFF, 32'd7, 32'd0, 32'd1000});
    check("identity_sat", 128'(last_sat), 128'(0));

    // half scale, round vs truncate
    send_beat({32'd5, 32'd1, 32'd2, 32'd3}, 32'h1, 32'h8000);
    wait_drain();
    check("round_lit", last_data, {32'd3, 32'd1, 32'd1, 32'd2});
    check("trunc_lit", last_trunc, {32'd2, 32'd0, 32'd1, 32'd1});

    // saturation, upper scale bits ignored
    send_beat({32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF}, 32'hABCD_FFFF, 32'h1234_FFFF);
    wait_drain();
    check("sat_lit", last_data, {32'd0, 32'd0, 32'h0000_FFFE, 32'hFFFF_FFFF});
    check("sat_flags", 128'(last_sat), 128'(4'b0001));

    // backpressure while streaming 6 beats
    chk_lat   = 1'b0;
    ready_low = 0;
    n_before  = n_out;
    fork
      for (int i = 0; i < 6; i++)
        send_beat({32'(i*100+3), 32'(i*100+2), 32'(i*100+1), 32'(i*100)}, 32'h100, 32'h100);
      begin
        repeat (4) @(posedge i_clk);
        #1 i_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_count", 128'(n_out - n_before), 128'(6));
    check("bp_ready_dropped", 128'(ready_low != 0), 128'(1));
    check("bp_last_lit", last_data, {32'd503, 32'd502, 32'd501, 32'd500});
    chk_lat = 1'b1;

    // per-beat scale sampling
    send_beat({96'd0, 32'd10}, 32'h100, 32'h100);
    send_beat({96'd0, 32'd10}, 32'h100, 32'h200);
    wait_drain();
    check("scale_a_lit", prev_data, {96'd0, 32'd10});
    check("scale_b_lit", last_data, {96'd0, 32'd20});

    // zero scale
    send_beat({32'd9, 32'd8, 32'd7, 32'd6}, 32'h0, 32'h1234);
    wait_drain();
    check("zero_scale_lit", last_data, 128'(0));

    // reset with three beats in flight
    n_before = n_out;
    send_beat({96'd0, 32'd1}, 32'h100, 32'h100);
    send_beat({96'd0, 32'd2}, 32'h100, 32'h100);
    send_beat({96'd0, 32'd3}, 32'h100, 32'h100);
    i_reset = 1'b1;
    #1;
    check("mid_rst_o_valid", 128'(o_valid), 128'(0));
    check("mid_rst_o_busy", 128'(o_busy), 128'(0));
    check("mid_rst_o_data", o_data, 128'(0));
    check("mid_rst_trunc_valid", 128'(o_valid_t), 128'(0));
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;
    repeat (10) @(posedge i_clk);
    #1;
    check("no_stale_valid", 128'(o_valid), 128'(0));
    check("no_stale_count", 128'(n_out - n_before), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dequant_pipe.md
Name: dequant_pipe

Overview:
Pipelined, multi-lane dequantizer that rescales LANES unsigned post-ReLU accumulator words by the product of the image and weight scale factors. Output is ((x * X_s[SCALE_W-1:0] * w_s[SCALE_W-1:0]) + rnd) >> FRAC_W, with optional round-half-up and unsigned saturation. Sits between the ReLU stage and the output writer of the NPU datapath. Uses a valid/ready handshake with full backpressure so it can be dropped into streaming paths.

Parameters:
LANES, 4, number of parallel data lanes per beat
DATA_W, 32, width of each input/output lane (unsigned)
SCALE_W, 16, low bits of each scale register used (the upper bits are ignored)
FRAC_W, 16, fractional bits removed by the final right shift
ROUND, 1, 1 = add 2^(FRAC_W-1) before the shift; 0 = truncate

Ports:
i_clk  input  1  clock, all state on rising edge
i_reset  input  1  asynchronous, active-high reset
i_X_s  input  32  image scale factor; bits [SCALE_W-1:0] used
i_w_s  input  32  weight scale factor; bits [SCALE_W-1:0] used
i_valid  input  1  input beat valid
o_ready  output  1  block can accept a beat this cycle
i_data  input  LANES*DATA_W  packed lanes, lane k at [k*DATA_W +: DATA_W]
o_valid  output  1  output beat valid
i_ready  input  1  downstream accepts the output beat
o_data  output  LANES*DATA_W  dequantized lanes, same packing as the input
o_sat  output  LANES  per-lane flag: the lane saturated in this beat
o_busy  output  1  at least one pipeline stage holds a valid beat

Behaviour:
- Reset (async assert, sync use after release): all stage valid bits = 0, o_valid = 0, o_data = 0, o_sat = 0, o_busy = 0. o_ready = 1 after reset.
- Three register stages (S1, S2, S3). Latency is 3 cycles from input handshake to o_valid when there is no stall. Throughput is 1 beat per cycle.
- Global advance = !S3.valid || i_ready. o_ready = advance (combinational). When advance = 0, all stages hold their contents, including bubbles.
- Input handshake = i_valid && o_ready. S1.valid <= handshake on advance.
- S1: register the lanes and scale = X_s[SCALE_W-1:0] * w_s[SCALE_W-1:0] (2*SCALE_W bits). The scales are sampled per beat, so a scale change between beats applies only to later beats.
- S2: prod_k = lane_k * scale, unsigned, DATA_W+2*SCALE_W bits, no truncation.
- S3: sum_k = prod_k + (ROUND ? 2^(FRAC_W-1) : 0), computed 1 bit wider so it cannot overflow. q_k = sum_k >> FRAC_W. If q_k > 2^DATA_W-1, the output lane = 2^DATA_W-1 and o_sat[k] = 1. Otherwise the output lane = q_k[DATA_W-1:0] and o_sat[k] = 0.
- o_data and o_sat are registered in S3 and stay stable while o_valid && !i_ready.
- o_busy = S1.valid | S2.valid | S3.valid.
- Boundaries:
  - lane = 0 or scale = 0 gives output 0, o_sat = 0.
  - FRAC_W = 0 with ROUND = 1 is illegal (checked by an elaboration assertion).
  - i_valid while o_ready = 0: the beat is not taken, and the source must hold it.
  - Reset mid-stream discards all in-flight beats with no partial output.
  - Beat order is preserved, with no loss or duplication.

Test Plan:
1. Identity: X_s=0x100, w_s=0x100 (scale 65536), lanes {1000,0,7,0xFFFF} -> after 3 cycles o_data={1000,0,7,0xFFFF}, o_sat=0.
2. Rounding: X_s=1, w_s=0x8000 (x0.5), lanes {3,2,1,5} -> ROUND=1 gives {2,1,1,3}; ROUND=0 build gives {1,1,0,2}.
3. Saturation and ignored bits: X_s=0xABCDFFFF, w_s=0x1234FFFF, lane0=0xFFFFFFFF, lane1=1 -> lane0=0xFFFFFFFF with o_sat[0]=1; lane1=0xFFFE with o_sat[1]=0 (the upper scale bits have no effect).
4. Backpressure: stream 6 beats back-to-back while i_ready=0 for cycles 4-8 -> o_ready drops once S3 is valid; o_data is held stable; all 6 beats come out in order with no duplicates after i_ready returns.
5. Per-beat scale: beat A with scale 65536 and beat B with scale 131072, same lane value 10 -> outputs 10 then 20.
6. Reset mid-stream: assert i_reset with 3 beats in flight -> o_valid, o_busy and o_data go to 0 immediately; no stale beat appears after release.
